// File: rtl/decode_out_pack.sv
// Packs the decoded byte stream into 64-bit little-endian words for the output FIFO and flushes a tagged last word on end-of-stream.
// Latency: a word is offered to the FIFO 1 cycle after its 8th byte; pack_done follows the last write by 1 cycle.
// Backpressure: fo_full stalls the hold register; pack_full stops decode_ctl once acc is also full or the stream is ending.
module decode_out_pack #(
    parameter int OUT_WIDTH  = 8,
    parameter int WORD_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OUT_WIDTH-1:0]  out_data,
    input  logic                  out_valid,
    input  logic                  all_end,
    output logic                  pack_full,
    input  logic                  fo_full,
    output logic                  fo_wr,
    output logic [WORD_WIDTH-1:0] fo_data,
    output logic [3:0]            fo_bytes,
    output logic                  fo_last,
    output logic                  pack_done,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic                  ovf
);

    localparam int         LANES     = WORD_WIDTH / OUT_WIDTH;
    localparam logic [3:0] LAST_LANE = 4'(LANES - 1);
    localparam logic [3:0] FULL_WORD = 4'(LANES);

    // RUN: accepting bytes; FLUSH: waiting to load the last word;
    // DRAIN: waiting for the last word to be written; DONE: idle until reset.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  acc_q, acc_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0]  wd_q, wd_d;
    logic [3:0]             wd_bytes_q, wd_bytes_d;
    logic                   wd_last_q, wd_last_d;
    logic                   wd_vld_q, wd_vld_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic                   word_done;
    logic                   hold_free;
    logic [WORD_WIDTH-1:0]  acc_merged;

    // The hold register is presented directly; a write only drops wd_vld,
    // so fo_data keeps the last word until a new one loads.
    assign fo_wr     = wd_vld_q & ~fo_full;
    assign fo_data   = wd_q;
    assign fo_bytes  = wd_bytes_q;
    assign fo_last   = wd_last_q;
    assign pack_done = done_q;
    assign byte_cnt  = byte_cnt_q;
    assign ovf       = ovf_q;

    // Only stop the source when the next byte would complete a word with
    // nowhere to put it, or once the stream has ended.
    assign pack_full = (wd_vld_q & ~fo_wr & (cnt_q == LAST_LANE)) | (state_q != RUN);

    assign accept    = out_valid & ~pack_full & (state_q == RUN);
    assign word_done = accept & (cnt_q == LAST_LANE);
    assign hold_free = ~wd_vld_q | fo_wr;

    // Accumulator with the incoming byte dropped into the lane at cnt.
    always_comb begin
        acc_merged = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == 4'(i)) begin
                acc_merged[i*OUT_WIDTH +: OUT_WIDTH] = out_data;
            end
        end
    end

    // Next-state logic: byte accept, word hand-off to the hold register, and the end-of-stream sequence.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        wd_bytes_d = wd_bytes_q;
        wd_last_d  = wd_last_q;
        wd_vld_d   = wd_vld_q & ~fo_wr;
        done_d     = done_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;

        // A byte offered while stalled or after the stream ended is a
        // protocol violation; it is dropped and flagged.
        if (out_valid && !accept) begin
            ovf_d = 1'b1;
        end

        if (accept) begin
            byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
            if (word_done) begin
                // pack_full guarantees the hold register is free or being written now.
                wd_d       = acc_merged;
                wd_bytes_d = FULL_WORD;
                wd_last_d  = 1'b0;
                wd_vld_d   = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = acc_merged;
                cnt_d = cnt_q + 4'd1;
            end
        end

        case (state_q)
            RUN: begin
                // Any byte in the all_end cycle was already taken above.
                if (all_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Always emit exactly one last word; an empty stream or an
                // exact multiple of 8 bytes produces a zero-byte marker.
                if (hold_free) begin
                    wd_d       = (cnt_q != 4'd0) ? acc_q : '0;
                    wd_bytes_d = cnt_q;
                    wd_last_d  = 1'b1;
                    wd_vld_d   = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The hold register holds only the last word here.
                if (fo_wr) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            acc_q      <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            wd_bytes_q <= '0;
            wd_last_q  <= 1'b0;
            wd_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            wd_bytes_q <= wd_bytes_d;
            wd_last_q  <= wd_last_d;
            wd_vld_q   <= wd_vld_d;
            done_q     <= done_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_decode_out_pack.sv
// Directed testbench for decode_out_pack.
// Inputs change 1-2 ns after the rising edge; FIFO writes are captured on the falling edge.
// The byte source honours pack_full except where a protocol violation is forced.
module tb_decode_out_pack;

    logic        clk;
    logic        rst;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        all_end;
    logic        pack_full;
    logic        fo_full;
    logic        fo_wr;
    logic [63:0] fo_data;
    logic [3:0]  fo_bytes;
    logic        fo_last;
    logic        pack_done;
    logic [31:0] byte_cnt;
    logic        ovf;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        last;
        int          cyc;
    } wr_rec_t;

    wr_rec_t wrs[$];
    int      checks;
    int      errors;
    int      cycle_cnt;
    int      done_cyc;
    int      drv_cyc;

    decode_out_pack dut (
        .clk       (clk),
        .rst       (rst),
        .out_data  (out_data),
        .out_valid (out_valid),
        .all_end   (all_end),
        .pack_full (pack_full),
        .fo_full   (fo_full),
        .fo_wr     (fo_wr),
        .fo_data   (fo_data),
        .fo_bytes  (fo_bytes),
        .fo_last   (fo_last),
        .pack_done (pack_done),
        .byte_cnt  (byte_cnt),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Capture every FIFO write and the first cycle pack_done is seen.
    always @(negedge clk) begin
        if (rst) begin
            if (fo_wr) begin
                wr_rec_t r;
                r.data  = fo_data;
                r.bytes = fo_bytes;
                r.last  = fo_last;
                r.cyc   = cycle_cnt;
                wrs.push_back(r);
            end
            if (pack_done && done_cyc < 0) done_cyc = cycle_cnt;
        end
    end

    function automatic wr_rec_t rec_at(int i);
        wr_rec_t r;
        r.data  = '1;
        r.bytes = 4'hF;
        r.last  = 1'b0;
        r.cyc   = -100;
        if (i < wrs.size()) r = wrs[i];
        return r;
    endfunction

    // One clock: set fo_full/all_end/data, then offer the byte unless pack_full (or forced).
    task automatic cyc(input logic v, input logic [7:0] d, input logic ae, input logic ff,
                       input logic frc, output logic acc);
        @(posedge clk);
        #1;
        drv_cyc  = cycle_cnt;
        fo_full  = ff;
        all_end  = ae;
        out_data = d;
        #1;
        acc       = v & ~pack_full;
        out_valid = frc ? v : (v & ~pack_full);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_valid = 1'b0;
        all_end   = 1'b0;
        fo_full   = 1'b0;
        out_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        done_cyc = -1;
        wrs.delete();
    endtask

    task automatic idle_until_done(input int max);
        logic a;
        for (int i = 0; i < max; i++) begin
            if (pack_done) break;
            cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic test_stream();
        logic a;
        int k8;
        int n;
        wr_rec_t r;
        do_reset();
        n  = 0;
        k8 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, a);
            if (a) n++;
            if (i == 7) k8 = drv_cyc;
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        idle_until_done(20);
        checks++; if (n !== 16) begin errors++; $display("FAIL stream_accepts: got %0d expected 16", n); end
        checks++; if (wrs.size() !== 3) begin errors++; $display("FAIL stream_writes: got %0d expected 3", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'h0706050403020100 || r.bytes !== 4'd8 || r.last !== 1'b0) begin errors++; $display("FAIL stream_word0: got %h/%0d/%b expected 0706050403020100/8/0", r.data, r.bytes, r.last); end
        checks++; if (r.cyc !== k8 + 1) begin errors++; $display("FAIL stream_first_latency: got cycle %0d expected %0d", r.cyc, k8 + 1); end
        r = rec_at(1);
        checks++; if (r.data !== 64'h0F0E0D0C0B0A0908 || r.bytes !== 4'd8 || r.last !== 1'b0) begin errors++; $display("FAIL stream_word1: got %h/%0d/%b expected 0f0e0d0c0b0a0908/8/0", r.data, r.bytes, r.last); end
        checks++; if (r.cyc !== k8 + 9) begin errors++; $display("FAIL back_to_back_gap: got cycle %0d expected %0d", r.cyc, k8 + 9); end
        r = rec_at(2);
        checks++; if (r.data !== 64'h0 || r.bytes !== 4'd0 || r.last !== 1'b1) begin errors++; $display("FAIL stream_marker: got %h/%0d/%b expected 0/0/1", r.data, r.bytes, r.last); end
        checks++; if (done_cyc !== r.cyc + 1) begin errors++; $display("FAIL stream_done_latency: got cycle %0d expected %0d", done_cyc, r.cyc + 1); end
        checks++; if (pack_done !== 1'b1 || byte_cnt !== 32'd16 || ovf !== 1'b0) begin errors++; $display("FAIL stream_status: got done=%b cnt=%0d ovf=%b expected 1/16/0", pack_done, byte_cnt, ovf); end
    endtask

    task automatic test_partial_end();
        logic a;
        wr_rec_t r;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), (i == 10), 1'b0, 1'b0, a);
        end
        idle_until_done(20);
        checks++; if (wrs.size() !== 2) begin errors++; $display("FAIL partial_writes: got %0d expected 2", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'hA7A6A5A4A3A2A1A0 || r.bytes !== 4'd8 || r.last !== 1'b0) begin errors++; $display("FAIL partial_word0: got %h/%0d/%b expected a7a6a5a4a3a2a1a0/8/0", r.data, r.bytes, r.last); end
        r = rec_at(1);
        checks++; if (r.data !== 64'h0000000000AAA9A8 || r.bytes !== 4'd3 || r.last !== 1'b1) begin errors++; $display("FAIL partial_last: got %h/%0d/%b expected 0000000000aaa9a8/3/1", r.data, r.bytes, r.last); end
        checks++; if (pack_done !== 1'b1 || byte_cnt !== 32'd11) begin errors++; $display("FAIL partial_status: got done=%b cnt=%0d expected 1/11", pack_done, byte_cnt); end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (fo_wr !== 1'b0 || pack_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got wr=%b full=%b expected 0/0", fo_wr, pack_full); end
        checks++; if (fo_data !== 64'h0 || fo_bytes !== 4'd0 || fo_last !== 1'b0) begin errors++; $display("FAIL reset_hold: got %h/%0d/%b expected 0/0/0", fo_data, fo_bytes, fo_last); end
        checks++; if (pack_done !== 1'b0 || byte_cnt !== 32'd0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_status: got done=%b cnt=%0d ovf=%b expected 0/0/0", pack_done, byte_cnt, ovf); end
    endtask

    task automatic test_backpressure();
        logic a;
        int idx;
        wr_rec_t r;
        do_reset();
        idx = 0;
        for (int c = 0; c < 25; c++) begin
            cyc((idx < 20), 8'(8'h30 + idx), 1'b0, 1'b1, 1'b0, a);
            if (a) idx++;
        end
        checks++; if (idx !== 15 || pack_full !== 1'b1) begin errors++; $display("FAIL bp_stall: got accepted=%0d full=%b expected 15/1", idx, pack_full); end
        checks++; if (wrs.size() !== 0 || byte_cnt !== 32'd15) begin errors++; $display("FAIL bp_no_write: got writes=%0d cnt=%0d expected 0/15", wrs.size(), byte_cnt); end
        for (int c = 0; c < 50 && idx < 20; c++) begin
            cyc(1'b1, 8'(8'h30 + idx), 1'b0, 1'b0, 1'b0, a);
            if (a) idx++;
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        idle_until_done(30);
        checks++; if (wrs.size() !== 3) begin errors++; $display("FAIL bp_writes: got %0d expected 3", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'h3736353433323130 || r.bytes !== 4'd8) begin errors++; $display("FAIL bp_word0: got %h/%0d expected 3736353433323130/8", r.data, r.bytes); end
        r = rec_at(1);
        checks++; if (r.data !== 64'h3F3E3D3C3B3A3938 || r.bytes !== 4'd8 || r.last !== 1'b0) begin errors++; $display("FAIL bp_word1: got %h/%0d/%b expected 3f3e3d3c3b3a3938/8/0", r.data, r.bytes, r.last); end
        r = rec_at(2);
        checks++; if (r.data !== 64'h0000000043424140 || r.bytes !== 4'd4 || r.last !== 1'b1) begin errors++; $display("FAIL bp_last: got %h/%0d/%b expected 0000000043424140/4/1", r.data, r.bytes, r.last); end
        checks++; if (ovf !== 1'b0 || byte_cnt !== 32'd20 || pack_done !== 1'b1) begin errors++; $display("FAIL bp_status: got ovf=%b cnt=%0d done=%b expected 0/20/1", ovf, byte_cnt, pack_done); end
    endtask

    task automatic test_illegal();
        logic a;
        int idx;
        wr_rec_t r;
        do_reset();
        idx = 0;
        for (int c = 0; c < 30 && idx < 15; c++) begin
            cyc(1'b1, 8'(8'h50 + idx), 1'b0, 1'b1, 1'b0, a);
            if (a) idx++;
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
        checks++; if (ovf !== 1'b0 || pack_full !== 1'b1) begin errors++; $display("FAIL ill_pre: got ovf=%b full=%b expected 0/1", ovf, pack_full); end
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, a);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
        checks++; if (ovf !== 1'b1 || byte_cnt !== 32'd15) begin errors++; $display("FAIL ill_flag: got ovf=%b cnt=%0d expected 1/15", ovf, byte_cnt); end
        for (int c = 0; c < 10 && idx < 16; c++) begin
            cyc(1'b1, 8'(8'h50 + idx), 1'b0, 1'b0, 1'b0, a);
            if (a) idx++;
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        idle_until_done(20);
        checks++; if (wrs.size() !== 3) begin errors++; $display("FAIL ill_writes: got %0d expected 3", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'h5756555453525150) begin errors++; $display("FAIL ill_word0: got %h expected 5756555453525150", r.data); end
        r = rec_at(1);
        checks++; if (r.data !== 64'h5F5E5D5C5B5A5958 || r.bytes !== 4'd8) begin errors++; $display("FAIL ill_word1: got %h/%0d expected 5f5e5d5c5b5a5958/8", r.data, r.bytes); end
        r = rec_at(2);
        checks++; if (r.bytes !== 4'd0 || r.last !== 1'b1) begin errors++; $display("FAIL ill_marker: got %0d/%b expected 0/1", r.bytes, r.last); end
        checks++; if (ovf !== 1'b1 || byte_cnt !== 32'd16) begin errors++; $display("FAIL ill_sticky: got ovf=%b cnt=%0d expected 1/16", ovf, byte_cnt); end
    endtask

    task automatic test_empty();
        logic a;
        wr_rec_t r;
        do_reset();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        idle_until_done(10);
        checks++; if (wrs.size() !== 1) begin errors++; $display("FAIL empty_writes: got %0d expected 1", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'h0 || r.bytes !== 4'd0 || r.last !== 1'b1) begin errors++; $display("FAIL empty_word: got %h/%0d/%b expected 0/0/1", r.data, r.bytes, r.last); end
        checks++; if (pack_done !== 1'b1 || byte_cnt !== 32'd0 || done_cyc !== r.cyc + 1) begin errors++; $display("FAIL empty_done: got done=%b cnt=%0d at %0d expected 1/0 at %0d", pack_done, byte_cnt, done_cyc, r.cyc + 1); end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        checks++; if (wrs.size() !== 1 || pack_done !== 1'b1) begin errors++; $display("FAIL done_ignores_end: got writes=%0d done=%b expected 1/1", wrs.size(), pack_done); end
    endtask

    task automatic test_reset_mid();
        logic a;
        wr_rec_t r;
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, a);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0, a);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, a);
        checks++; if (wrs.size() !== 1) begin errors++; $display("FAIL mid_reset_writes: got %0d expected 1", wrs.size()); end
        r = rec_at(0);
        checks++; if (r.data !== 64'h7776757473727170 || r.bytes !== 4'd8 || r.last !== 1'b0) begin errors++; $display("FAIL mid_reset_word: got %h/%0d/%b expected 7776757473727170/8/0", r.data, r.bytes, r.last); end
        checks++; if (byte_cnt !== 32'd8 || pack_done !== 1'b0) begin errors++; $display("FAIL mid_reset_status: got cnt=%0d done=%b expected 8/0", byte_cnt, pack_done); end
    endtask

    initial begin
        rst       = 1'b0;
        out_data  = 8'h00;
        out_valid = 1'b0;
        all_end   = 1'b0;
        fo_full   = 1'b0;
        checks    = 0;
        errors    = 0;
        done_cyc  = -1;
        drv_cyc   = 0;
        test_stream();
        test_partial_end();
        test_reset();
        test_backpressure();
        test_illegal();
        test_empty();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
